// File: rtl/rasterix_tex_pkg.sv
// Shared texture-path definitions: texel geometry, Q0.8 weight type and channel slicing.
// Used by the texture sampler, texel buffer and the bilinear filter.
package rasterix_tex_pkg;

  localparam int PIXEL_WIDTH   = 32;
  localparam int CHANNEL_WIDTH = 8;
  localparam int NUM_CHANNELS  = 4;
  localparam int WEIGHT_WIDTH  = 8;

  typedef logic [CHANNEL_WIDTH-1:0] channel_t;
  typedef logic [WEIGHT_WIDTH-1:0]  weight_t;

  // Channel 0 is the least significant byte (A); channel 3 is R.
  function automatic channel_t get_channel(input logic [PIXEL_WIDTH-1:0] px, input int idx);
    return px[idx*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  endfunction

endpackage

// File: rtl/tex_lerp8.sv
// Combinational 8-bit linear interpolation: y = (a*(256-w) + b*w) >> 8, truncating.
// The 16-bit sum peaks at 255*256, so the result always fits in 8 bits.
module tex_lerp8
  import rasterix_tex_pkg::*;
(
  input  channel_t a_i,
  input  channel_t b_i,
  input  weight_t  w_i,
  output channel_t y_o
);

  localparam logic [WEIGHT_WIDTH:0] W_ONE = {1'b1, {WEIGHT_WIDTH{1'b0}}};
  localparam int ACC_WIDTH = 2 * CHANNEL_WIDTH;

  logic [WEIGHT_WIDTH:0] w_inv;
  logic [ACC_WIDTH-1:0]  acc;

  assign w_inv = W_ONE - {1'b0, w_i};
  assign acc   = ({{(ACC_WIDTH-CHANNEL_WIDTH){1'b0}}, a_i} * {{(ACC_WIDTH-WEIGHT_WIDTH-1){1'b0}}, w_inv})
               + ({{(ACC_WIDTH-CHANNEL_WIDTH){1'b0}}, b_i} * {{(ACC_WIDTH-WEIGHT_WIDTH){1'b0}}, w_i});
  assign y_o   = channel_t'(acc >> CHANNEL_WIDTH);

endmodule

// File: rtl/texture_bilinear_filter.sv
// Three-stage bilinear filter of a 2x2 RGBA8888 quad with whole-pipeline stall and sideband tag.
// Blend arithmetic is built only with TEXTURE_BILINEAR_FILTER_EN; otherwise texel00 passes through at equal latency.
module texture_bilinear_filter #(
  parameter int PIXEL_WIDTH = 32,
  parameter int USER_WIDTH  = 16
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_texel00,
  input  logic [PIXEL_WIDTH-1:0] s_texel01,
  input  logic [PIXEL_WIDTH-1:0] s_texel10,
  input  logic [PIXEL_WIDTH-1:0] s_texel11,
  input  logic [15:0]            s_subCoordS,
  input  logic [15:0]            s_subCoordT,
  input  logic                   s_enableBilinear,
  input  logic [USER_WIDTH-1:0]  s_user,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_texel,
  output logic [USER_WIDTH-1:0]  m_user
);
  import rasterix_tex_pkg::*;

  logic                   advance;
  logic                   p1_valid_q, p2_valid_q, m_valid_q;
  logic [USER_WIDTH-1:0]  p1_user_q, p2_user_q, m_user_q;
  logic [PIXEL_WIDTH-1:0] p1_top_d, p1_top_q;
  logic [PIXEL_WIDTH-1:0] p2_texel_d, p2_texel_q;
  logic [PIXEL_WIDTH-1:0] m_texel_q;

  // Whole pipeline moves together; bubbles are never squeezed out.
  assign advance = !m_valid_q || m_ready;
  assign s_ready = advance;

`ifdef TEXTURE_BILINEAR_FILTER_EN
  weight_t                ws_d, wt_d, p1_wt_q;
  logic [PIXEL_WIDTH-1:0] p1_bot_d, p1_bot_q;

  // Zero weights make every lerp return its first operand, i.e. texel00 in nearest mode.
  assign ws_d = s_enableBilinear ? weight_t'(s_subCoordS[15:8]) : '0;
  assign wt_d = s_enableBilinear ? weight_t'(s_subCoordT[15:8]) : '0;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    tex_lerp8 u_p1_top (
      .a_i (get_channel(s_texel00, ch)),
      .b_i (get_channel(s_texel01, ch)),
      .w_i (ws_d),
      .y_o (p1_top_d[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
    tex_lerp8 u_p1_bot (
      .a_i (get_channel(s_texel10, ch)),
      .b_i (get_channel(s_texel11, ch)),
      .w_i (ws_d),
      .y_o (p1_bot_d[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
    tex_lerp8 u_p2 (
      .a_i (get_channel(p1_top_q, ch)),
      .b_i (get_channel(p1_bot_q, ch)),
      .w_i (p1_wt_q),
      .y_o (p2_texel_d[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      p1_bot_q <= '0;
      p1_wt_q  <= '0;
    end else if (advance && s_valid) begin
      p1_bot_q <= p1_bot_d;
      p1_wt_q  <= wt_d;
    end
  end
`else
  logic unused_filter_inputs;

  assign unused_filter_inputs = ^{s_texel01, s_texel10, s_texel11,
                                  s_subCoordS, s_subCoordT, s_enableBilinear};
  assign p1_top_d   = s_texel00;
  assign p2_texel_d = p1_top_q;
`endif

  // NOTE: non-blocking assignments let each stage capture the previous stage's pre-edge value.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      p1_user_q  <= '0;
      p2_user_q  <= '0;
      m_user_q   <= '0;
      p1_top_q   <= '0;
      p2_texel_q <= '0;
      m_texel_q  <= '0;
    end else if (advance) begin
      p1_valid_q <= s_valid;
      p2_valid_q <= p1_valid_q;
      m_valid_q  <= p2_valid_q;
      if (s_valid) begin
        p1_user_q <= s_user;
        p1_top_q  <= p1_top_d;
      end
      if (p1_valid_q) begin
        p2_user_q  <= p1_user_q;
        p2_texel_q <= p2_texel_d;
      end
      if (p2_valid_q) begin
        m_user_q  <= p2_user_q;
        m_texel_q <= p2_texel_q;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_texel = m_texel_q;
  assign m_user  = m_user_q;

endmodule

// File: tb/tb_texture_bilinear_filter.sv
// Directed bench for texture_bilinear_filter: vector table plus latency, backpressure and mid-stream reset sequences.
// Expected texels follow TEXTURE_BILINEAR_FILTER_EN (filtered value) or texel00 when the macro is absent.
module tb_texture_bilinear_filter;

`ifdef TEXTURE_BILINEAR_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_texel00, s_texel01, s_texel10, s_texel11;
  logic [15:0] s_subCoordS, s_subCoordT;
  logic        s_enableBilinear;
  logic [15:0] s_user;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_texel;
  logic [15:0] m_user;

  texture_bilinear_filter #(.PIXEL_WIDTH(32), .USER_WIDTH(16)) dut (
    .aclk             (aclk),
    .reset            (reset),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_texel00        (s_texel00),
    .s_texel01        (s_texel01),
    .s_texel10        (s_texel10),
    .s_texel11        (s_texel11),
    .s_subCoordS      (s_subCoordS),
    .s_subCoordT      (s_subCoordT),
    .s_enableBilinear (s_enableBilinear),
    .s_user           (s_user),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_texel          (m_texel),
    .m_user           (m_user)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] t00, t01, t10, t11;
    logic [15:0] sub_s, sub_t;
    logic        bil;
    logic [31:0] exp_filt;
  } vec_t;

  typedef struct {
    logic [31:0] texel;
    logic [15:0] user;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] held_texel;
  logic [15:0] held_user;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] t00, input logic [31:0] t01,
                              input logic [31:0] t10, input logic [31:0] t11,
                              input logic [15:0] sub_s, input logic [15:0] sub_t,
                              input logic bil, input logic [31:0] exp_filt);
    vec_t v;
    v.t00 = t00; v.t01 = t01; v.t10 = t10; v.t11 = t11;
    v.sub_s = sub_s; v.sub_t = sub_t; v.bil = bil; v.exp_filt = exp_filt;
    return v;
  endfunction

  function automatic logic [31:0] expected_of(input vec_t v);
    return FILTER_ON ? v.exp_filt : v.t00;
  endfunction

  task automatic drive(input vec_t v, input logic [15:0] user);
    s_valid          = 1'b1;
    s_texel00        = v.t00;
    s_texel01        = v.t01;
    s_texel10        = v.t10;
    s_texel11        = v.t11;
    s_subCoordS      = v.sub_s;
    s_subCoordT      = v.sub_t;
    s_enableBilinear = v.bil;
    s_user           = user;
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic step(input logic [31:0] exp_texel, output bit accepted);
    exp_t e;
    #1;
    check("s_ready_comb", {31'd0, s_ready}, {31'd0, (!m_valid || m_ready)});
    if (hold_pending) begin
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_texel", m_texel, held_texel);
      check("hold_user", {16'd0, m_user}, {16'd0, held_user});
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL spurious_output: got texel %h user %h, expected no output", m_texel, m_user);
      end else begin
        e = exp_q.pop_front();
        check("out_texel", m_texel, e.texel);
        check("out_user", {16'd0, m_user}, {16'd0, e.user});
      end
    end
    accepted = s_valid && s_ready;
    if (accepted) begin
      e.texel = exp_texel;
      e.user  = s_user;
      exp_q.push_back(e);
    end
    hold_pending = m_valid && !m_ready;
    held_texel   = m_texel;
    held_user    = m_user;
    @(negedge aclk);
  endtask

  task automatic drain(input string name);
    bit acc;
    int n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      step(32'd0, acc);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    bit          acc;
    int          idx;
    int          cyc;
    logic [31:0] bp_exp;

    vecs[0] = mk(32'h10203040, 32'h50607080, 32'hAAAAAAAA, 32'hAAAAAAAA, 16'h8000, 16'h0000, 1'b1, 32'h30405060);
    vecs[1] = mk(32'h10203040, 32'h50607080, 32'hAAAAAAAA, 32'hAAAAAAAA, 16'h80FF, 16'h00FF, 1'b1, 32'h30405060);
    vecs[2] = mk(32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000000);
    vecs[3] = mk(32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 16'h0000, 16'h0000, 1'b1, 32'hFFFFFFFF);
    vecs[4] = mk(32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h8000, 16'h8000, 1'b0, 32'h11223344);
    vecs[5] = mk(32'h00000000, 32'h12345678, 32'hFEFEFEFE, 32'h12345678, 16'h0000, 16'h8000, 1'b1, 32'h7F7F7F7F);
    vecs[6] = mk(32'h00000000, 32'h80808080, 32'h40404040, 32'hC0C0C0C0, 16'h4000, 16'hC000, 1'b1, 32'h50505050);
    vecs[7] = mk(32'hFF000080, 32'h00FF8000, 32'h00000000, 32'h00000000, 16'hC000, 16'h0000, 1'b1, 32'h3FBF6020);
    vecs[8] = mk(32'h01010101, 32'h02020202, 32'h00000000, 32'h00000000, 16'h8000, 16'h0000, 1'b1, 32'h01010101);
    vecs[9] = mk(32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, 16'hFFFF, 16'h0000, 1'b0, 32'hDEADBEEF);

    reset = 1'b1;
    m_ready = 1'b0;
    drive(vecs[0], 16'h0000);
    s_valid = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_texel", m_texel, 32'd0);
    check("rst_m_user", {16'd0, m_user}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    reset = 1'b0;
    @(negedge aclk);

    // Single beat: three-cycle latency and tag echo.
    m_ready = 1'b1;
    drive(vecs[0], 16'h1234);
    step(expected_of(vecs[0]), acc);
    check("lat_accept", {31'd0, acc}, 32'd1);
    s_valid = 1'b0;
    check("lat_n1", {31'd0, m_valid}, 32'd0);
    step(32'd0, acc);
    check("lat_n2", {31'd0, m_valid}, 32'd0);
    step(32'd0, acc);
    check("lat_n3", {31'd0, m_valid}, 32'd1);
    step(32'd0, acc);
    check("lat_done", exp_q.size(), 32'd0);

    // Vector table streamed back to back at full throughput.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i], 16'(16'h0100 + i));
      step(expected_of(vecs[i]), acc);
      check("vec_accept", {31'd0, acc}, 32'd1);
    end
    drain("vec_drain");

    // Backpressure: ten tagged beats with random downstream readiness.
    idx = 0;
    cyc = 0;
    while ((idx < 10 || exp_q.size() > 0) && cyc < 400) begin
      bp_exp = 32'((idx + 1) * 32'h01010101);
      if (idx < 10) begin
        drive(mk(bp_exp, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0000, 16'h0000, 1'b1, bp_exp),
              16'(idx));
      end else begin
        s_valid = 1'b0;
      end
      m_ready = 1'($urandom_range(0, 1));
      step(bp_exp, acc);
      if (acc) idx++;
      cyc++;
    end
    check("bp_all_sent", idx, 32'd10);
    check("bp_drained", exp_q.size(), 32'd0);

    // Reset with three beats in flight: none may reappear.
    hold_pending = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[6 + i], 16'(16'h0200 + i));
      step(expected_of(vecs[6 + i]), acc);
      check("mid_accept", {31'd0, acc}, 32'd1);
    end
    s_valid = 1'b0;
    check("mid_full", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_texel", m_texel, 32'd0);
    check("mid_rst_user", {16'd0, m_user}, 32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
    exp_q.delete();
    hold_pending = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_idle", {31'd0, m_valid}, 32'd0);
      step(32'd0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
